// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one synchronous image ROM between the background drawer
// (port 0) and the sprite drawer (port 1). One read accepted per clock; each returned
// pixel is steered back to the port that issued it via a valid/tag shift register.
// Build macro ROM_ARB_RR_EN: when defined, contention is resolved by strict round-robin;
// when undefined, port 0 has fixed priority and port 1 is protected by an aging counter.

module rom_access_arbiter #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   typedef enum logic [1:0] {StIdle = 2'd0, StServe0 = 2'd1, StServe1 = 2'd2} state_e;

   state_e            state_q, state_d;
   logic              win0, win1;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   // Stage k holds the read accepted k+1 edges ago; stage ROM_LAT lines up with rom_data.
   logic [ROM_LAT:0]  vld_q, vld_d, tag_q, tag_d;
   logic              ret0, ret1;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              rvalid0_q, rvalid1_q;

`ifdef ROM_ARB_RR_EN
   logic last1_q, last1_d;

   // Round-robin pick: on contention the port that did not win most recently goes first.
   always_comb begin
      win0    = req0 & (~req1 | last1_q);
      win1    = req1 & (~req0 | ~last1_q);
      last1_d = last1_q;
      if (win0) begin
         last1_d = 1'b0;
      end else if (win1) begin
         last1_d = 1'b1;
      end
   end

   // Last-winner bit starts on port 1 so port 0 takes the first contention.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last1_q <= 1'b1;
      end else begin
         last1_q <= last1_d;
      end
   end
`else
   logic [3:0] wait1_q, wait1_d;
   logic       aged;

   // Fixed priority to port 0 unless port 1 has been refused MAX_WAIT times in a row.
   always_comb begin
      aged    = (wait1_q >= 4'(MAX_WAIT));
      win1    = req1 & (~req0 | aged);
      win0    = req0 & ~win1;
      wait1_d = wait1_q;
      if (!req1 || win1) begin
         wait1_d = '0;
      end else if (wait1_q != 4'hf) begin
         wait1_d = wait1_q + 4'd1;
      end
   end

   // Aging counter register for port 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait1_q <= '0;
      end else begin
         wait1_q <= wait1_d;
      end
   end
`endif

   // Next state, ROM address and tag pipeline push for the accepted port.
   always_comb begin
      state_d    = StIdle;
      rom_addr_d = rom_addr_q;
      if (win0) begin
         state_d    = StServe0;
         rom_addr_d = addr0;
      end else if (win1) begin
         state_d    = StServe1;
         rom_addr_d = addr1;
      end
      vld_d = {vld_q[ROM_LAT-1:0], win0 | win1};
      tag_d = {tag_q[ROM_LAT-1:0], win1};
      ret0  = vld_q[ROM_LAT] & ~tag_q[ROM_LAT];
      ret1  = vld_q[ROM_LAT] & tag_q[ROM_LAT];
   end

   // State, address, pipeline and return registers; reset drops every in-flight read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         rom_addr_q <= '0;
         vld_q      <= '0;
         tag_q      <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         vld_q      <= vld_d;
         tag_q      <= tag_d;
         rvalid0_q  <= ret0;
         rvalid1_q  <= ret1;
         if (ret0) begin
            rdata0_q <= rom_data;
         end
         if (ret1) begin
            rdata1_q <= rom_data;
         end
      end
   end

   assign gnt0     = (state_q == StServe0);
   assign gnt1     = (state_q == StServe1);
   assign rom_addr = rom_addr_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: directed vector table, hand-written contention sequence
// and randomized traffic, all checked against a transaction-level reference model.
// Honours ROM_ARB_RR_EN the same way as the design.

module tb_rom_access_arbiter;

   localparam int AW  = 12;
   localparam int DW  = 12;
   localparam int LAT = 1;
   localparam int MW  = 4;

   logic          clk;
   logic          rst;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic          gnt0, gnt1;
   logic [DW-1:0] rdata0, rdata1;
   logic          rvalid0, rvalid1;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   rom_access_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .ROM_LAT (LAT),
      .MAX_WAIT(MW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .addr0   (addr0),
      .gnt0    (gnt0),
      .rdata0  (rdata0),
      .rvalid0 (rvalid0),
      .req1    (req1),
      .addr1   (addr1),
      .gnt1    (gnt1),
      .rdata1  (rdata1),
      .rvalid1 (rvalid1),
      .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: an arbitrary scrambling of the address.
   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return (a ^ 12'h5a5) + {a[5:0], a[11:6]};
   endfunction

   // Synchronous ROM, data valid LAT clocks after the address is presented.
   logic [DW-1:0] rom_pipe [LAT];
   always @(posedge clk) begin
      rom_pipe[0] <= rom_f(rom_addr);
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[LAT-1];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      int            due;
      logic          port;
      logic [AW-1:0] addr;
   } ret_t;

   ret_t          pend[$];
   int            streak = 0;
   logic          last_p1 = 1'b1;
   logic          e_g0 = 1'b0, e_g1 = 1'b0, e_rv0 = 1'b0, e_rv1 = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_rd0 = '0, e_rd1 = '0;

   task automatic model_step();
      int   win;
      ret_t r;
      cyc++;
      if (!rst) begin
         pend.delete();
         {e_g0, e_g1, e_rv0, e_rv1} = 4'b0;
         e_addr  = '0;
         e_rd0   = '0;
         e_rd1   = '0;
         streak  = 0;
         last_p1 = 1'b1;
      end else begin
         e_rv0 = 1'b0;
         e_rv1 = 1'b0;
         if (pend.size() != 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.port) begin
               e_rv1 = 1'b1;
               e_rd1 = rom_f(r.addr);
            end else begin
               e_rv0 = 1'b1;
               e_rd0 = rom_f(r.addr);
            end
         end
         win = -1;
`ifdef ROM_ARB_RR_EN
         if (req0 && req1) win = last_p1 ? 0 : 1;
         else if (req0)    win = 0;
         else if (req1)    win = 1;
         if (win >= 0) last_p1 = (win == 1);
`else
         if (req0 && req1) win = (streak >= MW) ? 1 : 0;
         else if (req0)    win = 0;
         else if (req1)    win = 1;
         if (req1 && win != 1) streak = (streak < 15) ? streak + 1 : 15;
         else                  streak = 0;
`endif
         e_g0 = (win == 0);
         e_g1 = (win == 1);
         if (win == 0) e_addr = addr0;
         if (win == 1) e_addr = addr1;
         if (win >= 0) pend.push_back('{cyc + 1 + LAT, (win == 1), e_addr});
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Continuous comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("gnt0", 32'(gnt0), 32'(e_g0));
         chk("gnt1", 32'(gnt1), 32'(e_g1));
         chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
         chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
         chk("rv_exclusive", 32'(rvalid0 & rvalid1), 32'(0));
         chk("rom_addr", 32'(rom_addr), 32'(e_addr));
         chk("rdata0", 32'(rdata0), 32'(e_rd0));
         chk("rdata1", 32'(rdata1), 32'(e_rd1));
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rst, r0, r1;
      logic [AW-1:0] a0, a1;
      logic          g0, g1, v0, v1;
      logic          ca;
      logic [AW-1:0] ea, da;
      logic          z;
   } vec_t;

   vec_t vecs[$];

   // Inputs for one cycle, then outputs expected during that same cycle.
   task automatic add(input int rs, input int r0, input int a0, input int r1, input int a1,
                      input int g0, input int g1, input int v0, input int v1,
                      input int ca, input int ea, input int da, input int z);
      vec_t v;
      v.rst = 1'(rs);  v.r0 = 1'(r0);  v.a0 = AW'(a0); v.r1 = 1'(r1); v.a1 = AW'(a1);
      v.g0  = 1'(g0);  v.g1 = 1'(g1);  v.v0 = 1'(v0);  v.v1 = 1'(v1);
      v.ca  = 1'(ca);  v.ea = AW'(ea); v.da = AW'(da); v.z  = 1'(z);
      vecs.push_back(v);
   endtask

   initial begin
      int k;
      logic exp_p1;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

      //  rst r0 a0     r1 a1     g0 g1 v0 v1 ca ea     da     z
      // reset state, then a single port-0 read
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 1, 'h123, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 1, 0, 0, 0, 1, 'h123, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 1, 'h123, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 0, 'h000, 'h123, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      // back-to-back port 0
      add(1, 1, 'h010, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 1, 'h011, 0, 'h000, 1, 0, 0, 0, 1, 'h010, 'h000, 0);
      add(1, 1, 'h012, 0, 'h000, 1, 0, 0, 0, 1, 'h011, 'h000, 0);
      add(1, 1, 'h013, 0, 'h000, 1, 0, 1, 0, 1, 'h012, 'h010, 0);
      add(1, 0, 'h000, 0, 'h000, 1, 0, 1, 0, 1, 'h013, 'h011, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 1, 'h013, 'h012, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 0, 'h000, 'h013, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      // single port-1 read
      add(1, 0, 'h000, 1, 'h0ab, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 1, 0, 0, 1, 'h0ab, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 1, 0, 'h000, 'h0ab, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      // reset with two reads in flight, then a single read after release
      add(1, 1, 'h200, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 1, 'h201, 0, 'h000, 1, 0, 0, 0, 1, 'h200, 'h000, 0);
      add(0, 0, 'h000, 0, 'h000, 1, 0, 0, 0, 1, 'h201, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 1, 'h321, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 1);
      add(1, 0, 'h000, 0, 'h000, 1, 0, 0, 0, 1, 'h321, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 0, 'h000, 'h000, 0);
      add(1, 0, 'h000, 0, 'h000, 0, 0, 1, 0, 0, 'h000, 'h321, 0);
      // idle: nothing moves, rom_addr holds
      for (int i = 0; i < 10; i++) begin
         add(1, 0, 'h000, 0, 'h000, 0, 0, 0, 0, 1, 'h321, 'h000, 0);
      end

      repeat (2) @(posedge clk);
      chk_en = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         rst = vecs[i].rst; req0 = vecs[i].r0; addr0 = vecs[i].a0;
         req1 = vecs[i].r1; addr1 = vecs[i].a1;
         @(negedge clk);
         chk($sformatf("vec%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
         chk($sformatf("vec%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
         chk($sformatf("vec%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
         chk($sformatf("vec%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
         if (vecs[i].v0) chk($sformatf("vec%0d rdata0", i), 32'(rdata0), 32'(rom_f(vecs[i].da)));
         if (vecs[i].v1) chk($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(rom_f(vecs[i].da)));
         if (vecs[i].ca) chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].ea));
         if (vecs[i].z) begin
            chk($sformatf("vec%0d rom_addr_zero", i), 32'(rom_addr), 32'(0));
            chk($sformatf("vec%0d rdata0_zero", i), 32'(rdata0), 32'(0));
            chk($sformatf("vec%0d rdata1_zero", i), 32'(rdata1), 32'(0));
         end
      end

      // ---------------- contention: both ports requesting continuously ----------------
      @(posedge clk); #1;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; req0 = 1'b1; addr0 = 12'h400; req1 = 1'b1; addr1 = 12'h800;
      for (k = 0; k < 20; k++) begin
         @(posedge clk); #1;
`ifdef ROM_ARB_RR_EN
         exp_p1 = (k % 2 == 1);
`else
         exp_p1 = (k % (MW + 1) == MW);
`endif
         chk($sformatf("contend%0d gnt0", k), 32'(gnt0), 32'(!exp_p1));
         chk($sformatf("contend%0d gnt1", k), 32'(gnt1), 32'(exp_p1));
         if (gnt0) addr0 = addr0 + 12'd1;
         if (gnt1) addr1 = addr1 + 12'd1;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(posedge clk);

      // ---------------- randomized traffic under the requester rule ----------------
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 49) != 0);
         if (req0 && gnt0) begin
            if ($urandom_range(0, 3) != 0) addr0 = AW'($urandom);
            else req0 = 1'b0;
         end else if (!req0 && $urandom_range(0, 1) == 1) begin
            req0 = 1'b1; addr0 = AW'($urandom);
         end
         if (req1 && gnt1) begin
            if ($urandom_range(0, 3) != 0) addr1 = AW'($urandom);
            else req1 = 1'b0;
         end else if (!req1 && $urandom_range(0, 2) != 0) begin
            req1 = 1'b1; addr1 = AW'($urandom);
         end
      end
      @(posedge clk); #1;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
